// File: rtl/clk_freq_meter_module.sv
// clk_freq_meter_module: counts rising edges of an async signal per gate window and measures its period.
`timescale 1ns/1ps
module clk_freq_meter_module #(
  parameter int unsigned P_GATE_CNT    = 1000,
  parameter int          P_COUNT_WIDTH = 16
) (
  input  logic                     i_sysclk,
  input  logic                     i_sysrst,
  input  logic                     i_en,
  input  logic                     i_signal,
  output logic [P_COUNT_WIDTH-1:0] o_edge_cnt,
  output logic                     o_valid,
  output logic                     o_ovf,
  output logic                     o_no_signal,
  output logic [P_COUNT_WIDTH-1:0] o_period,
  output logic                     o_period_valid
);
  localparam logic [31:0]              GATE_LAST = 32'(P_GATE_CNT - 1);
  localparam logic [P_COUNT_WIDTH-1:0] MAX       = '1;
  localparam logic [P_COUNT_WIDTH-1:0] ONE       = P_COUNT_WIDTH'(1);
  (* ASYNC_REG = "TRUE" *) logic r_s1;
  (* ASYNC_REG = "TRUE" *) logic r_s2;
  logic                     r_s3;
  logic [31:0]              r_gate;
  logic [P_COUNT_WIDTH-1:0] r_edge;
  logic [P_COUNT_WIDTH-1:0] r_per;
  logic [P_COUNT_WIDTH-1:0] edge_nxt;
  logic                     r_sat;
  logic                     sat_nxt;
  logic                     r_armed;
  logic                     w_pos;
  logic                     w_close;
  always_comb begin
    w_pos    = r_s2 & ~r_s3;
    w_close  = i_en && (r_gate == GATE_LAST);
    edge_nxt = (w_pos && r_edge != MAX) ? r_edge + ONE : r_edge;
    sat_nxt  = r_sat | (w_pos && r_edge == MAX);
  end
  // synchronizer free-runs so a level already present at enable is never seen as an edge
  always_ff @(posedge i_sysclk or posedge i_sysrst)
    if (i_sysrst) {r_s1, r_s2, r_s3} <= '0;
    else          {r_s1, r_s2, r_s3} <= {i_signal, r_s1, r_s2};
  always_ff @(posedge i_sysclk or posedge i_sysrst)
    if (i_sysrst) begin
      r_gate         <= '0;
      r_edge         <= '0;
      r_sat          <= 1'b0;
      r_per          <= '0;
      r_armed        <= 1'b0;
      o_edge_cnt     <= '0;
      o_valid        <= 1'b0;
      o_ovf          <= 1'b0;
      o_no_signal    <= 1'b0;
      o_period       <= '0;
      o_period_valid <= 1'b0;
    end else if (!i_en) begin
      r_gate         <= '0;
      r_edge         <= '0;
      r_sat          <= 1'b0;
      r_per          <= '0;
      r_armed        <= 1'b0;
      o_valid        <= 1'b0;
      o_period_valid <= 1'b0;
    end else begin
      r_gate         <= w_close ? '0 : r_gate + 32'd1;
      r_edge         <= w_close ? '0 : edge_nxt;
      r_sat          <= w_close ? 1'b0 : sat_nxt;
      o_valid        <= w_close;
      if (w_close) begin
        o_edge_cnt  <= edge_nxt;
        o_ovf       <= sat_nxt;
        o_no_signal <= (edge_nxt == '0);
      end
      r_per          <= w_pos ? ONE : (r_per == MAX ? r_per : r_per + ONE);
      r_armed        <= r_armed | w_pos;
      o_period_valid <= w_pos & r_armed;
      if (w_pos && r_armed) o_period <= r_per;
    end
endmodule

// File: tb/tb_clk_freq_meter_module.sv
// tb_clk_freq_meter_module: scoreboard bench for the edge-count/period meter at W=16 and W=4.
`timescale 1ns/1ps
module tb_clk_freq_meter_module;
  typedef struct {int cnt; bit ovf; bit nos;} res_t;
  logic clk, rst;
  logic en16, sig16, en4, sig4;
  logic [15:0] cnt16, per16_o;
  logic [3:0]  cnt4, per4_o;
  logic v16, ovf16, nos16, pv16, v4, ovf4, nos4, pv4;
  int per16, per4, ph16, ph4, exp_per16, exp_per4, pv_n4;
  logic lvl16, lvl4;
  int errors = 0;
  int checks = 0;
  res_t q16[$];
  res_t q4[$];
  res_t e16, e4;
  clk_freq_meter_module #(.P_GATE_CNT(1000), .P_COUNT_WIDTH(16)) u16 (
    .i_sysclk(clk), .i_sysrst(rst), .i_en(en16), .i_signal(sig16),
    .o_edge_cnt(cnt16), .o_valid(v16), .o_ovf(ovf16), .o_no_signal(nos16),
    .o_period(per16_o), .o_period_valid(pv16));
  clk_freq_meter_module #(.P_GATE_CNT(1000), .P_COUNT_WIDTH(4)) u4 (
    .i_sysclk(clk), .i_sysrst(rst), .i_en(en4), .i_signal(sig4),
    .o_edge_cnt(cnt4), .o_valid(v4), .o_ovf(ovf4), .o_no_signal(nos4),
    .o_period(per4_o), .o_period_valid(pv4));
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  function automatic res_t mk(input int c, input bit o, input bit n);
    res_t r;
    r.cnt = c; r.ovf = o; r.nos = n;
    return r;
  endfunction
  task automatic wait_empty(input bit sel, input int budget);
    int n = 0;
    while ((sel ? q4.size() : q16.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sel ? q4.size() != 0 : q16.size() != 0) begin
      check(sel ? "timeout4" : "timeout16", sel ? q4.size() : q16.size(), 0);
      if (sel) q4.delete(); else q16.delete();
    end
  endtask
  task automatic wait_valid16(input string tag, input int exp_n);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!v16 && n < 2000);
    check(tag, n, exp_n);
  endtask
  initial clk = 0;
  always #5 clk = ~clk;
  initial forever begin
    @(negedge clk);
    if (per16 == 0) begin sig16 = lvl16; ph16 = 0; end
    else begin ph16 = (ph16 >= per16 - 1) ? 0 : ph16 + 1; sig16 = (ph16 < per16 / 2); end
    if (per4 == 0) begin sig4 = lvl4; ph4 = 0; end
    else begin ph4 = (ph4 >= per4 - 1) ? 0 : ph4 + 1; sig4 = (ph4 < per4 / 2); end
  end
  initial forever begin
    @(negedge clk);
    if (v16) begin
      if (q16.size() == 0) check("v16_unexp", 1, 0);
      else begin
        e16 = q16.pop_front();
        check("cnt16", cnt16, e16.cnt);
        check("ovf16", ovf16, e16.ovf);
        check("nos16", nos16, e16.nos);
      end
    end
    if (v4) begin
      if (q4.size() == 0) check("v4_unexp", 1, 0);
      else begin
        e4 = q4.pop_front();
        check("cnt4", cnt4, e4.cnt);
        check("ovf4", ovf4, e4.ovf);
        check("nos4", nos4, e4.nos);
      end
    end
    if (pv16) begin
      if (exp_per16 == 0) check("pv16_unexp", 1, 0);
      else check("per16", per16_o, exp_per16);
    end
    if (pv4) begin
      pv_n4++;
      if (exp_per4 == 0) check("pv4_unexp", 1, 0);
      else check("per4", per4_o, exp_per4);
    end
  end
  initial begin
    rst = 1; en16 = 0; en4 = 0; per16 = 0; per4 = 0; lvl16 = 0; lvl4 = 0;
    ph16 = 0; ph4 = 0; sig16 = 0; sig4 = 0; exp_per16 = 0; exp_per4 = 0; pv_n4 = 0;
    repeat (3) @(negedge clk);
    check("rst_cnt", cnt16, 0);
    check("rst_valid", v16, 0);
    check("rst_ovf", ovf16, 0);
    check("rst_nos", nos16, 0);
    check("rst_per", per16_o, 0);
    check("rst_pv", pv16, 0);
    rst = 0;
    q16.push_back(mk(0, 0, 1));
    q16.push_back(mk(0, 0, 1));
    en16 = 1;
    wait_empty(0, 2100);
    en16 = 0; lvl16 = 1;
    repeat (10) @(negedge clk);
    q16.push_back(mk(0, 0, 1));
    en16 = 1;
    wait_empty(0, 1100);
    check("per16_idle", per16_o, 0);
    en16 = 0; per16 = 10;
    repeat (30) @(negedge clk);
    exp_per16 = 10;
    repeat (3) q16.push_back(mk(100, 0, 0));
    en16 = 1;
    wait_empty(0, 3100);
    repeat (500) @(negedge clk);
    en16 = 0;
    repeat (50) @(negedge clk);
    check("hold_cnt", cnt16, 100);
    check("hold_per", per16_o, 10);
    q16.push_back(mk(100, 0, 0));
    en16 = 1;
    wait_valid16("reen_lat", 1000);
    per16 = 0; lvl16 = 0;
    repeat (30) @(negedge clk);
    exp_per16 = 0;
    repeat (300) @(negedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1;
    check("arst_cnt", cnt16, 0);
    check("arst_per", per16_o, 0);
    check("arst_ovf", ovf16, 0);
    check("arst_nos", nos16, 0);
    check("arst_valid", v16, 0);
    check("arst_pv", pv16, 0);
    @(negedge clk);
    rst = 0;
    q16.push_back(mk(0, 0, 1));
    wait_valid16("rst_lat", 1000);
    en16 = 0;
    per4 = 4;
    repeat (20) @(negedge clk);
    exp_per4 = 4;
    q4.push_back(mk(15, 1, 0));
    en4 = 1;
    wait_empty(1, 1100);
    q4.push_back(mk(15, 1, 0));
    q4.push_back(mk(0, 0, 1));
    repeat (500) @(negedge clk);
    per4 = 0; lvl4 = 0;
    repeat (30) @(negedge clk);
    exp_per4 = 0;
    wait_empty(1, 1600);
    en4 = 0; per4 = 20;
    repeat (50) @(negedge clk);
    exp_per4 = 15; pv_n4 = 0;
    q4.push_back(mk(15, 1, 0));
    en4 = 1;
    wait_empty(1, 1100);
    check("pv4_cnt_ok", pv_n4 >= 40, 1);
    en4 = 0;
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
